// File: rtl/alu_pipe.sv
// Handshaked 16-op ALU with registered {N,Z,C,V} flags and an iterative
// shift-add multiplier; at most one operation is in flight at a time.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0]   CNT_MAX = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0]   AMT_ONE = SHW'(1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic {IDLE, MUL} state_t;
    state_t state, state_nxt;

    logic                    accept, drain, mul_done, upd_carry, carry_q;
    logic [SHW-1:0]          cnt, amt, amt_m1;
    logic [WIDTH-1:0]        mcand, mplier, acc, acc_nxt;
    logic [WIDTH-1:0]        res_c, sh_t, fsrc;
    logic [WIDTH:0]          ext;
    logic signed [WIDTH-1:0] a_s;
    logic                    c_c, v_c;
    logic [3:0]              flags_c;

    function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign mul_done  = (state == MUL) && (cnt == '0);
    assign busy      = (state == MUL);
    assign upd_carry = ((op >= 4'd4) && (op <= 4'd8)) || (op == 4'd13);
    assign amt       = b[SHW-1:0];
    assign amt_m1    = amt - AMT_ONE;
    assign a_s       = a;
    assign acc_nxt   = mplier[0] ? acc + mcand : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && op == 4'd12) state_nxt = MUL;
            MUL:     if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle result and flags, evaluated on the operands being accepted
    always_comb begin
        res_c = '0;
        ext   = '0;
        sh_t  = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        case (op)
            4'd0: res_c = a & b;
            4'd1: res_c = a | b;
            4'd2: res_c = a ^ b;
            4'd3: res_c = ~a;
            4'd4: begin
                ext   = {1'b0, a} + {1'b0, b};
                res_c = ext[WIDTH-1:0];
                c_c   = ext[WIDTH];
                v_c   = add_ovf(a, b, ext[WIDTH-1:0]);
            end
            4'd5, 4'd13: begin
                ext   = {1'b0, a} - {1'b0, b};
                res_c = (op == 4'd13) ? a : ext[WIDTH-1:0];
                c_c   = ext[WIDTH];
                v_c   = sub_ovf(a, b, ext[WIDTH-1:0]);
            end
            4'd6: begin
                ext   = {1'b0, a} - {1'b0, ONE};
                res_c = ext[WIDTH-1:0];
                c_c   = ext[WIDTH];
                v_c   = sub_ovf(a, ONE, ext[WIDTH-1:0]);
            end
            4'd7: begin
                ext   = {1'b0, a} + {1'b0, ONE};
                res_c = ext[WIDTH-1:0];
                c_c   = ext[WIDTH];
                v_c   = add_ovf(a, ONE, ext[WIDTH-1:0]);
            end
            4'd8: begin
                ext   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_q};
                res_c = ext[WIDTH-1:0];
                c_c   = ext[WIDTH];
                v_c   = add_ovf(a, b, ext[WIDTH-1:0]);
            end
            // Carry is the last bit shifted out: shift by one less and look at the edge bit
            4'd9: begin
                res_c = a << amt;
                sh_t  = a << amt_m1;
                c_c   = (amt != '0) && sh_t[WIDTH-1];
            end
            4'd10: begin
                res_c = a >> amt;
                sh_t  = a >> amt_m1;
                c_c   = (amt != '0) && sh_t[0];
            end
            4'd11: begin
                res_c = a_s >>> amt;
                sh_t  = a >> amt_m1;
                c_c   = (amt != '0) && sh_t[0];
            end
            4'd14:   res_c = b;
            default: res_c = '0;
        endcase
        fsrc    = (op == 4'd13) ? ext[WIDTH-1:0] : res_c;
        flags_c = (op == 4'd15) ? 4'b0000 : {fsrc[WIDTH-1], fsrc == '0, c_c, v_c};
    end

    // Output register, carry and multiplier datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
        end else begin
            if (accept) begin
                if (op == 4'd12) begin
                    mcand     <= a;
                    mplier    <= b;
                    acc       <= '0;
                    cnt       <= CNT_MAX;
                    out_valid <= 1'b0;
                end else begin
                    result    <= res_c;
                    flags     <= flags_c;
                    out_valid <= 1'b1;
                    if (upd_carry) carry_q <= c_c;
                end
            end else if (mul_done) begin
                result    <= acc_nxt;
                flags     <= {acc_nxt[WIDTH-1], acc_nxt == '0, 2'b00};
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (state == MUL) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - AMT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed vector table, hand-written
// back-pressure / reset sequences, and random ops against an arithmetic model.
module tb_alu_pipe;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] a, b, result;
    logic [3:0] op, flags;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .busy(busy)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] r;
        logic [3:0] f;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode rules
    function automatic void model(input logic [7:0] ma, input logic [7:0] mb, input logic [3:0] mop,
                                  input logic cin, output logic [7:0] r, output logic [3:0] f);
        int ai, bi, sa, y, sy, s, sv, n, ci;
        logic c, v, arith;
        logic [7:0] d;
        ai = int'(ma); bi = int'(mb); sa = int'($signed(ma));
        n = bi % 8; ci = cin ? 1 : 0;
        c = 1'b0; v = 1'b0; r = 8'h00; d = 8'h00; arith = 1'b0;
        case (mop)
            4'd0: r = ma & mb;
            4'd1: r = ma | mb;
            4'd2: r = ma ^ mb;
            4'd3: r = ~ma;
            4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd13: begin
                arith = 1'b1;
                y  = (mop == 4'd6 || mop == 4'd7) ? 1 : bi;
                sy = (mop == 4'd6 || mop == 4'd7) ? 1 : int'($signed(mb));
                if (mop == 4'd5 || mop == 4'd6 || mop == 4'd13) begin
                    s = ai - y; sv = sa - sy; c = (ai < y);
                end else begin
                    s = ai + y + ((mop == 4'd8) ? ci : 0);
                    sv = sa + sy + ((mop == 4'd8) ? ci : 0);
                    c = (s > 255);
                end
                v = (sv > 127) || (sv < -128);
                d = 8'(s & 255);
                r = (mop == 4'd13) ? ma : d;
            end
            4'd9: begin
                r = 8'((ai << n) & 255);
                c = (n != 0) && (((ai >> (8 - n)) & 1) == 1);
            end
            4'd10: begin
                r = 8'(ai >> n);
                c = (n != 0) && (((ai >> (n - 1)) & 1) == 1);
            end
            4'd11: begin
                r = 8'((sa >>> n) & 255);
                c = (n != 0) && (((ai >> (n - 1)) & 1) == 1);
            end
            4'd12: r = 8'((ai * bi) & 255);
            4'd14: r = mb;
            default: r = 8'h00;
        endcase
        if (!arith) d = r;
        f = (mop == 4'd15) ? 4'b0000 : {d[7], d == 8'h00, c, v};
    endfunction

    // Called at a falling edge; returns at the falling edge where out_valid is first seen
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic [3:0] top,
                          output logic [7:0] r, output logic [3:0] f,
                          output int lat, output int bcnt, output int icnt);
        int guard;
        a = ta; b = tbv; op = top; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("issue_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; bcnt = 0; icnt = 0;
        while (!out_valid && lat < 40) begin
            bcnt += int'(busy);
            icnt += int'(in_ready);
            @(negedge clk);
            lat++;
        end
        bcnt += int'(busy);
        r = result; f = flags;
    endtask

    vec_t       tbl[21];
    logic [7:0] r, er;
    logic [3:0] f, ef;
    logic       carry_m;
    int         lat, bc, ic, vcnt;

    initial begin
        tbl[0]  = '{8'hFF, 8'h01, 4'd4,  8'h00, 4'b0110};
        tbl[1]  = '{8'h10, 8'h20, 4'd8,  8'h31, 4'b0000};
        tbl[2]  = '{8'h80, 8'h01, 4'd5,  8'h7F, 4'b0001};
        tbl[3]  = '{8'h05, 8'h09, 4'd13, 8'h05, 4'b1010};
        tbl[4]  = '{8'h90, 8'h03, 4'd11, 8'hF2, 4'b1000};
        tbl[5]  = '{8'h81, 8'h01, 4'd9,  8'h02, 4'b0010};
        tbl[6]  = '{8'h81, 8'h09, 4'd9,  8'h02, 4'b0010};
        tbl[7]  = '{8'h0D, 8'h0B, 4'd12, 8'h8F, 4'b1000};
        tbl[8]  = '{8'h10, 8'h10, 4'd12, 8'h00, 4'b0100};
        tbl[9]  = '{8'h81, 8'h01, 4'd10, 8'h40, 4'b0010};
        tbl[10] = '{8'hF0, 8'h3C, 4'd0,  8'h30, 4'b0000};
        tbl[11] = '{8'h00, 8'h00, 4'd1,  8'h00, 4'b0100};
        tbl[12] = '{8'hAA, 8'h55, 4'd2,  8'hFF, 4'b1000};
        tbl[13] = '{8'h0F, 8'h00, 4'd3,  8'hF0, 4'b1000};
        tbl[14] = '{8'h00, 8'h00, 4'd6,  8'hFF, 4'b1010};
        tbl[15] = '{8'h01, 8'h01, 4'd8,  8'h03, 4'b0000};
        tbl[16] = '{8'h7F, 8'h00, 4'd7,  8'h80, 4'b1001};
        tbl[17] = '{8'h00, 8'h80, 4'd14, 8'h80, 4'b1000};
        tbl[18] = '{8'h12, 8'h34, 4'd15, 8'h00, 4'b0000};
        tbl[19] = '{8'h7F, 8'h00, 4'd11, 8'h7F, 4'b0000};
        tbl[20] = '{8'h40, 8'h07, 4'd10, 8'h00, 4'b0110};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 8'h00; b = 8'h00; op = 4'd0; carry_m = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    32'(result),    32'h00);
        chk("rst_flags",     32'(flags),     32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_busy",      32'(busy),      32'd0);

        for (int i = 0; i < 21; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].op, r, f, lat, bc, ic);
            chk($sformatf("vec%0d_result", i), 32'(r), 32'(tbl[i].r));
            chk($sformatf("vec%0d_flags", i),  32'(f), 32'(tbl[i].f));
            chk($sformatf("vec%0d_latency", i), 32'(lat), (tbl[i].op == 4'd12) ? 32'd9 : 32'd1);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), (tbl[i].op == 4'd12) ? 32'd8 : 32'd0);
            chk($sformatf("vec%0d_ready_while_busy", i), 32'(ic), 32'd0);
            if ((tbl[i].op >= 4'd4 && tbl[i].op <= 4'd8) || tbl[i].op == 4'd13) carry_m = tbl[i].f[1];
        end

        // Back-pressure: INC held under out_ready=0, a second op waits at the input
        @(negedge clk);
        out_ready = 1'b0;
        a = 8'h41; b = 8'h00; op = 4'd7; in_valid = 1'b1;
        @(negedge clk);
        a = 8'h01; b = 8'h02; op = 4'd4;
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_result",    32'(result),    32'h42);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_valid",  32'(out_valid), 32'd1);
        chk("bp_next_result", 32'(result),    32'h03);
        chk("bp_next_flags",  32'(flags),     32'h0);
        carry_m = 1'b0;
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [7:0] ra, rb;
            logic [3:0] rop;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rop = 4'($urandom_range(0, 15));
            model(ra, rb, rop, carry_m, er, ef);
            run_op(ra, rb, rop, r, f, lat, bc, ic);
            chk($sformatf("rnd%0d_op%0d_result", i, rop), 32'(r), 32'(er));
            chk($sformatf("rnd%0d_op%0d_flags", i, rop),  32'(f), 32'(ef));
            chk($sformatf("rnd%0d_op%0d_latency", i, rop), 32'(lat), (rop == 4'd12) ? 32'd9 : 32'd1);
            if ((rop >= 4'd4 && rop <= 4'd8) || rop == 4'd13) carry_m = ef[1];
        end

        // Leave carry_q set, then reset in the middle of a multiply
        run_op(8'hFF, 8'h01, 4'd4, r, f, lat, bc, ic);
        chk("pre_rst_flags", 32'(f), 32'b0110);
        a = 8'hFF; b = 8'hFF; op = 4'd12; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_mul_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_result",    32'(result),    32'h00);
        chk("mid_rst_flags",     32'(flags),     32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            vcnt += int'(out_valid);
        end
        chk("no_stale_result", 32'(vcnt), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        run_op(8'h00, 8'h00, 4'd8, r, f, lat, bc, ic);
        chk("post_rst_addc_result", 32'(r), 32'h00);
        chk("post_rst_addc_flags",  32'(f), 32'b0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
